// File: rtl/tts_pkg.sv
// Shared types for the host command master: RAM select encoding, FSM states
// and the predicate that identifies the 64-bit-wide RAMs.
package tts_pkg;

  typedef enum logic [1:0] {
    SEL_SYMBOL = 2'd0,
    SEL_PRICE  = 2'd1,
    SEL_VOLUME = 2'd2,
    SEL_ORDER  = 2'd3
  } cmd_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RSP     = 2'd3
  } state_e;

  // Symbol and volume RAMs are only 64 bits wide; everything above bit 63 is dead.
  function automatic logic is_64b_ram(input logic [1:0] sel);
    return (sel == SEL_SYMBOL) || (sel == SEL_VOLUME);
  endfunction

endpackage

// File: rtl/host_cmd_master_if.sv
// Command, host-port and response buses of the host command master.
// All three channels transfer on a clock edge where the producer's valid/req and
// the consumer's ready/ack are both 1; the producer holds its payload stable until then.
interface host_cmd_master_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 128
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [1:0]            cmd_sel;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  host_req;
  logic                  host_wr;
  logic [1:0]            host_sel;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic                  host_rvalid;
  logic [DATA_WIDTH-1:0] host_rdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata,
    output cmd_ready,
    output host_req, host_wr, host_sel, host_addr, host_wdata,
    input  host_ack, host_rvalid, host_rdata,
    output rsp_valid, rsp_err, rsp_rdata,
    input  rsp_ready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_sel, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  host_req, host_wr, host_sel, host_addr, host_wdata,
    output host_ack, host_rvalid, host_rdata,
    input  rsp_valid, rsp_err, rsp_rdata,
    output rsp_ready
  );
endinterface

// File: rtl/host_cmd_master.sv
// Single-outstanding host-port initiator: accepts one command, drives the host
// request until acked, waits for read data or a timeout, then returns a response.
module host_cmd_master
  import tts_pkg::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  host_cmd_master_if.master  bus,
  output logic [15:0]        timeout_cnt,
  output state_e             fsm_state
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DATA_WIDTH-1:0] LO64_MASK = DATA_WIDTH'({64{1'b1}});

  state_e                state, state_nxt;
  logic                  lat_write;
  logic [1:0]            lat_sel;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [TW-1:0]         tmr;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic                  cmd_ready;
  logic                  accept;
  logic                  load_rsp;
  logic                  err_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic [DATA_WIDTH-1:0] rdata_masked;
  logic                  timeout_hit;

  assign cmd_ready    = (state == ST_IDLE) && !reset;
  assign accept       = cmd_ready && bus.cmd_valid;
  assign rdata_masked = is_64b_ram(lat_sel) ? (bus.host_rdata & LO64_MASK) : bus.host_rdata;
  assign timeout_hit  = (tmr == TW'(TIMEOUT_CYCLES - 1));

  // Completion is tested before timeout so a late ack/rvalid still wins.
  always_comb begin
    state_nxt = state;
    load_rsp  = 1'b0;
    err_nxt   = 1'b0;
    rdata_nxt = '0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.host_ack) begin
          if (lat_write) begin
            state_nxt = ST_RSP;
            load_rsp  = 1'b1;
          end else if (bus.host_rvalid) begin
            state_nxt = ST_RSP;
            load_rsp  = 1'b1;
            rdata_nxt = rdata_masked;
          end else begin
            state_nxt = ST_WAIT_RD;
          end
        end else if (timeout_hit) begin
          state_nxt = ST_RSP;
          load_rsp  = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      ST_WAIT_RD: begin
        if (bus.host_rvalid) begin
          state_nxt = ST_RSP;
          load_rsp  = 1'b1;
          rdata_nxt = rdata_masked;
        end else if (timeout_hit) begin
          state_nxt = ST_RSP;
          load_rsp  = 1'b1;
          err_nxt   = 1'b1;
        end
      end
      ST_RSP: if (bus.rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      lat_write   <= 1'b0;
      lat_sel     <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      tmr         <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      timeout_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_write <= bus.cmd_write;
        lat_sel   <= bus.cmd_sel;
        lat_addr  <= bus.cmd_addr;
        lat_wdata <= bus.cmd_wdata;
        tmr       <= '0;
      end else if (state == ST_REQ || state == ST_WAIT_RD) begin
        tmr <= tmr + TW'(1);
      end
      if (load_rsp) begin
        rsp_err_q   <= err_nxt;
        rsp_rdata_q <= rdata_nxt;
        if (err_nxt && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.host_req   = (state == ST_REQ);
  assign bus.host_wr    = lat_write;
  assign bus.host_sel   = lat_sel;
  assign bus.host_addr  = lat_addr;
  assign bus.host_wdata = is_64b_ram(lat_sel) ? (lat_wdata & LO64_MASK) : lat_wdata;
  assign bus.rsp_valid  = (state == ST_RSP);
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign fsm_state      = state;

endmodule
